// File: rtl/ped_request_unit.sv
// ped_request_unit: debounces the pedestrian button and holds a request toward the controller until walk is shown.
// Blinks the WAIT lamp while the request is pending and enforces a cooldown after each walk phase.
module ped_request_unit #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int BLINK_HALF = 6000000,
    parameter int COOLDOWN_CYCLES = 60000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic       walk_active,
    output logic       req,
    output logic       wait_led,
    output logic [7:0] press_cnt
);
    localparam logic [1:0] IDLE = 2'd0, PENDING = 2'd1, SERVING = 2'd2, COOLDOWN = 2'd3;
    localparam logic [31:0] DEB_MAX = 32'(DEBOUNCE_CYCLES - 1);
    localparam logic [31:0] BLINK_MAX = 32'(BLINK_HALF - 1);
    localparam logic [31:0] COOL_LOAD = 32'(COOLDOWN_CYCLES);

    logic s1, s2, deb, deb_d, press;
    logic [1:0] state;
    logic [31:0] deb_cnt, blink_cnt, cool_cnt;

    assign press = deb & ~deb_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            deb <= 1'b0;
            deb_d <= 1'b0;
            deb_cnt <= '0;
            blink_cnt <= '0;
            cool_cnt <= '0;
            state <= IDLE;
            req <= 1'b0;
            wait_led <= 1'b0;
            press_cnt <= '0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
            deb_d <= deb;
            if (s2 == deb)
                deb_cnt <= '0;
            else if (deb_cnt == DEB_MAX) begin
                deb <= s2;
                deb_cnt <= '0;
            end else
                deb_cnt <= deb_cnt + 32'd1;
            // only presses seen in IDLE are counted, including one coinciding with walk
            if (press && state == IDLE && press_cnt != 8'hff)
                press_cnt <= press_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (walk_active)
                        state <= SERVING;
                    else if (press) begin
                        state <= PENDING;
                        req <= 1'b1;
                        wait_led <= 1'b1;
                        blink_cnt <= '0;
                    end
                end
                PENDING: begin
                    if (walk_active) begin
                        state <= SERVING;
                        req <= 1'b0;
                        wait_led <= 1'b0;
                    end else if (blink_cnt == BLINK_MAX) begin
                        wait_led <= ~wait_led;
                        blink_cnt <= '0;
                    end else
                        blink_cnt <= blink_cnt + 32'd1;
                end
                SERVING: begin
                    if (!walk_active) begin
                        state <= COOLDOWN;
                        cool_cnt <= COOL_LOAD;
                    end
                end
                default: begin
                    if (walk_active)
                        state <= SERVING;
                    else if (cool_cnt == '0)
                        state <= IDLE;
                    else
                        cool_cnt <= cool_cnt - 32'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ped_request_unit.sv
// tb_ped_request_unit: scoreboard bench; a cycle model queues expected outputs as stimulus is driven.
module tb_ped_request_unit;
    localparam int DC = 4, BH = 3, CD = 5;

    logic clk = 1'b0, rst = 1'b1, btn_raw = 1'b0, walk_active = 1'b0;
    logic req, wait_led;
    logic [7:0] press_cnt;

    ped_request_unit #(.DEBOUNCE_CYCLES(DC), .BLINK_HALF(BH), .COOLDOWN_CYCLES(CD)) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .walk_active(walk_active),
        .req(req), .wait_led(wait_led), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r;
        logic w;
        logic [7:0] p;
    } exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    string phase = "init";

    bit m_s1, m_s2, m_deb, m_debd, m_req, m_wl;
    int m_cnt, m_bc, m_cd, m_st, m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h at %0t", phase, tag, obs, expv, $time);
        end
    endtask

    task automatic model(input bit b, input bit w, input bit r);
        bit pr;
        if (r) begin
            {m_s1, m_s2, m_deb, m_debd, m_req, m_wl} = '0;
            m_cnt = 0; m_bc = 0; m_cd = 0; m_st = 0; m_pc = 0;
        end else begin
            pr = m_deb && !m_debd;
            if (pr && m_st == 0 && m_pc < 255) m_pc++;
            case (m_st)
                0: if (w) m_st = 2;
                   else if (pr) begin m_st = 1; m_req = 1; m_wl = 1; m_bc = 0; end
                1: if (w) begin m_st = 2; m_req = 0; m_wl = 0; end
                   else if (m_bc == BH - 1) begin m_wl = !m_wl; m_bc = 0; end
                   else m_bc++;
                2: if (!w) begin m_st = 3; m_cd = CD; end
                default: if (w) m_st = 2; else if (m_cd == 0) m_st = 0; else m_cd--;
            endcase
            m_debd = m_deb;
            if (m_s2 == m_deb) m_cnt = 0;
            else if (m_cnt == DC - 1) begin m_deb = m_s2; m_cnt = 0; end
            else m_cnt++;
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    task automatic step(input bit b, input bit w, input bit r);
        exp_t e;
        model(b, w, r);
        sb.push_back('{r: m_req, w: m_wl, p: 8'(m_pc)});
        btn_raw = b;
        walk_active = w;
        rst = r;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("req", 32'(req), 32'(e.r));
        chk("wait_led", 32'(wait_led), 32'(e.w));
        chk("press_cnt", 32'(press_cnt), 32'(e.p));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    initial begin
        logic wl_pat[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        phase = "reset";
        step(1, 0, 1);
        step(1, 0, 1);
        chk("req0", 32'(req), 0);
        chk("wl0", 32'(wait_led), 0);
        chk("pc0", 32'(press_cnt), 0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0);
            if (i == 6) chk("req_e6", 32'(req), 0);
            if (i == 7) chk("req_e7", 32'(req), 1);
        end

        phase = "glitch";
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        idle_n(6);
        for (int i = 0; i < 20; i++) step(i[0] == 1'b0, 0, 0);
        idle_n(8);
        chk("req", 32'(req), 0);
        chk("pc", 32'(press_cnt), 0);

        phase = "clean";
        for (int i = 1; i <= 10; i++) begin
            step(1, 0, 0);
            if (i == 6) chk("req_e6", 32'(req), 0);
            if (i == 7) chk("req_e7", 32'(req), 1);
            if (i == 7) chk("pc_e7", 32'(press_cnt), 1);
            if (i >= 7) chk("wl_pat", 32'(wait_led), 32'(wl_pat[i-7]));
        end
        idle_n(10);

        phase = "handshake";
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0);
            if (i == 0) chk("req_walk", 32'(req), 0);
            if (i == 0) chk("wl_walk", 32'(wait_led), 0);
        end
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        chk("cool_req", 32'(req), 0);
        chk("cool_pc", 32'(press_cnt), 1);
        idle_n(8);
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0);
            if (i == 7) chk("req2", 32'(req), 1);
        end
        chk("pc2", 32'(press_cnt), 2);
        idle_n(7);
        step(0, 1, 0);
        step(0, 1, 0);
        idle_n(10);

        phase = "priority";
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, i >= 7, 0);
        chk("req", 32'(req), 0);
        chk("pc", 32'(press_cnt), 1);
        idle_n(20);
        chk("req_after", 32'(req), 0);

        phase = "saturate";
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 7; i++) step(1, 0, 0);
            idle_n(7);
            step(0, 1, 0);
            step(0, 1, 0);
            idle_n(8);
        end
        chk("pc255", 32'(press_cnt), 255);

        phase = "midreset";
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        chk("req_pend", 32'(req), 1);
        step(1, 0, 1);
        chk("req", 32'(req), 0);
        chk("wl", 32'(wait_led), 0);
        chk("pc", 32'(press_cnt), 0);
        for (int i = 1; i <= 7; i++) step(1, 0, 0);
        chk("req_fresh", 32'(req), 1);
        chk("pc_fresh", 32'(press_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
